// File: rtl/ex_stage.sv
// Execute stage: base-ISA ALU plus optional RV32M multiply/iterative divide, feeding the EX/MEM register.
// Macro RISCV_CPU_MULDIV_EN enables RV32M; without it, M-ops retire with illegal_o set.
module ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SIDE_WIDTH = 96
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    input  logic [3:0]            alu_op_i,
    input  logic                  md_en_i,
    input  logic [2:0]            md_op_i,
    input  logic [SIDE_WIDTH-1:0] side_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [SIDE_WIDTH-1:0] side_o,
    output logic                  illegal_o
);
    localparam int W = DATA_WIDTH;

    logic                  out_valid_q;
    logic [W-1:0]          result_q;
    logic [SIDE_WIDTH-1:0] out_side_q;
    logic                  illegal_q;

    logic                  slot_free;
    logic                  accept;
    logic [4:0]            shamt;
    logic [W-1:0]          alu_res;

    logic                  load;
    logic [W-1:0]          load_res;
    logic [SIDE_WIDTH-1:0] load_side;
    logic                  load_ill;

    assign slot_free = !out_valid_q || out_ready_i;
    assign accept    = in_valid_i && in_ready_o;
    assign shamt     = op_b_i[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            4'd0: alu_res = op_a_i + op_b_i;
            4'd1: alu_res = op_a_i - op_b_i;
            4'd2: alu_res = op_a_i << shamt;
            4'd3: alu_res = {{(W-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            4'd4: alu_res = {{(W-1){1'b0}}, (op_a_i < op_b_i)};
            4'd5: alu_res = op_a_i ^ op_b_i;
            4'd6: alu_res = op_a_i >> shamt;
            4'd7: alu_res = $unsigned($signed(op_a_i) >>> shamt);
            4'd8: alu_res = op_a_i | op_b_i;
            4'd9: alu_res = op_a_i & op_b_i;
            default: alu_res = '0;
        endcase
    end

`ifdef RISCV_CPU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_DIV_BUSY, S_DIV_DONE} state_e;
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    state_e                state_q, state_d;
    logic [4:0]            count_q;
    logic [W-1:0]          divisor_q, quot_q, rem_q;
    logic                  q_neg_q, r_neg_q, is_rem_q;
    logic [SIDE_WIDTH-1:0] div_side_q;
    logic                  div_done_load;

    // Multiplier: extend each operand to 2W by its signedness; low 2W product bits are exact.
    logic                  a_sgn_mul, b_sgn_mul;
    logic [2*W-1:0]        mul_a_ext, mul_b_ext, product;
    logic [W-1:0]          mul_res;

    assign a_sgn_mul = (md_op_i[1:0] == 2'd1) || (md_op_i[1:0] == 2'd2);
    assign b_sgn_mul = (md_op_i[1:0] == 2'd1);
    assign mul_a_ext = {{W{a_sgn_mul & op_a_i[W-1]}}, op_a_i};
    assign mul_b_ext = {{W{b_sgn_mul & op_b_i[W-1]}}, op_b_i};
    assign product   = mul_a_ext * mul_b_ext;
    assign mul_res   = (md_op_i[1:0] == 2'd0) ? product[W-1:0] : product[2*W-1:W];

    logic          is_div_op, div_signed, a_neg, b_neg, div_zero, div_ovf, div_special, go_div;
    logic [W-1:0]  a_abs, b_abs, special_res, md_res;

    assign is_div_op   = md_en_i && md_op_i[2];
    assign div_signed  = !md_op_i[0];
    assign a_neg       = div_signed && op_a_i[W-1];
    assign b_neg       = div_signed && op_b_i[W-1];
    assign a_abs       = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    assign b_abs       = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    assign div_zero    = (op_b_i == '0);
    assign div_ovf     = div_signed && (op_a_i == INT_MIN) && (op_b_i == '1);
    assign div_special = div_zero || div_ovf;
    assign special_res = div_zero ? (md_op_i[1] ? op_a_i : '1)
                                  : (md_op_i[1] ? '0 : INT_MIN);
    assign md_res      = md_op_i[2] ? special_res : mul_res;
    assign go_div      = accept && is_div_op && !div_special;

    // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    logic [W+1:0]  trial;
    logic          step_sub;
    logic [W-1:0]  rem_step, q_fix, r_fix, div_res;

    assign trial    = {1'b0, rem_q, quot_q[W-1]} - {2'b00, divisor_q};
    assign step_sub = (trial[W+1:W] == 2'b00);
    assign rem_step = step_sub ? trial[W-1:0] : {rem_q[W-2:0], quot_q[W-1]};
    assign q_fix    = q_neg_q ? (~quot_q + 1'b1) : quot_q;
    assign r_fix    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    assign div_res  = is_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (go_div) state_d = S_DIV_BUSY;
            S_DIV_BUSY: if (count_q == 5'd31) state_d = S_DIV_DONE;
            S_DIV_DONE: if (slot_free) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_comb begin
        in_ready_o    = (state_q == S_IDLE) && slot_free;
        div_done_load = (state_q == S_DIV_DONE) && slot_free;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            is_rem_q   <= 1'b0;
            div_side_q <= '0;
        end else if (go_div) begin
            count_q    <= '0;
            divisor_q  <= b_abs;
            quot_q     <= a_abs;
            rem_q      <= '0;
            q_neg_q    <= a_neg ^ b_neg;
            r_neg_q    <= a_neg;
            is_rem_q   <= md_op_i[1];
            div_side_q <= side_i;
        end else if (state_q == S_DIV_BUSY) begin
            count_q <= count_q + 5'd1;
            quot_q  <= {quot_q[W-2:0], step_sub};
            rem_q   <= rem_step;
        end
    end

    assign load      = (accept && !go_div) || div_done_load;
    assign load_res  = div_done_load ? div_res : (md_en_i ? md_res : alu_res);
    assign load_side = div_done_load ? div_side_q : side_i;
    assign load_ill  = 1'b0;
`else
    logic unused_md_op;

    assign unused_md_op = ^md_op_i;
    assign in_ready_o   = slot_free;
    assign load         = accept;
    assign load_res     = md_en_i ? '0 : alu_res;
    assign load_side    = side_i;
    assign load_ill     = md_en_i;
`endif

    // Flush outranks any load, including a divide completing this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_side_q  <= '0;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_res;
            out_side_q  <= load_side;
            illegal_q   <= load_ill;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign side_o      = out_side_q;
    assign illegal_o   = illegal_q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline, directly upstream of the memory stage.
- Accepts decoded operands from ID and computes base-ISA ALU results. Optionally computes RV32M multiply/divide results.
- Registers the result, plus an opaque sideband (rd, write-enable, mem controls, pc, branch info), into the EX/MEM pipeline register consumed by MEM.
- Division is iterative and multi-cycle; the stage back-pressures ID with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width. Only 32 is supported.
- SIDE_WIDTH, 96, width of the opaque sideband carried unchanged from ID to MEM.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous kill of in-flight op and output register (branch taken in MEM)
- in_valid_i  in  1  ID presents an op
- in_ready_o  out  1  EX accepts op this cycle
- op_a_i  in  DATA_WIDTH  operand A
- op_b_i  in  DATA_WIDTH  operand B (register or immediate, selected in ID)
- alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 result 0
- md_en_i  in  1  op is RV32M; alu_op_i ignored
- md_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- side_i  in  SIDE_WIDTH  sideband, latched on accept
- out_valid_o  out  1  EX/MEM register holds a valid op
- out_ready_i  in  1  MEM consumes output this cycle
- result_o  out  DATA_WIDTH  registered result (MEM uses it as memory address / branch operand)
- side_o  out  SIDE_WIDTH  registered sideband
- illegal_o  out  1  registered; op was RV32M but the M extension is compiled out

Behaviour:
- Reset: state IDLE; out_valid_o, result_o, side_o, illegal_o all 0; divider registers 0.
- Accept: in_valid_i && in_ready_o.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). It is combinational, with no dependence on in_valid_i.
- Output register loads when any of these holds:
  - accept of an ALU/MUL op;
  - accept of a DIV-class op on the special path (see below);
  - DIV_DONE with the slot free (!out_valid_o || out_ready_i).
- Otherwise out_valid_o clears when out_ready_i, and holds while !out_ready_i.
- ALU and MUL ops: latency 1. The result appears on the cycle after accept.
  - Shifts use op_b_i[4:0].
  - SLT is signed and SLTU unsigned; each yields 0 or 1.
  - MUL returns the low 32 bits of the 64-bit product. MULH/MULHSU/MULHU return the high 32 bits, signed×signed, signed×unsigned and unsigned×unsigned respectively.
- Divider FSM: IDLE -> DIV_BUSY -> DIV_DONE -> IDLE.
  - IDLE, on accept of DIV/DIVU/REM/REMU: latch side_i, the operand absolute values and the sign flags; set count=0; go to DIV_BUSY.
  - DIV_BUSY: one restoring radix-2 step per cycle. After the 32nd step (count==31) go to DIV_DONE.
  - DIV_DONE: apply the sign correction. The quotient sign is signA^signB; the remainder takes the sign of the dividend.
  - DIV_DONE loads the output and returns to IDLE when the slot is free; otherwise it stays in DIV_DONE.
  - Normal divide latency: 34 cycles from accept to out_valid_o, with out_ready_i held high.
- Special divide cases complete with latency 1 and never enter DIV_BUSY:
  - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - signed overflow, 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- flush_i has priority over everything:
  - next state IDLE, out_valid_o=0, illegal_o=0;
  - any accept in the same cycle is discarded;
  - an in-progress divide is abandoned.
- Reset asserted mid-divide returns the stage to the reset values immediately (asynchronous).
- result_o and side_o hold their value while out_valid_o && !out_ready_i.

Optional Feature:
- Macro: RISCV_CPU_MULDIV_EN.
- Defined: full RV32M support as above.
- Undefined: no multiplier or divider logic; state is always IDLE.
  - An accepted md_en_i op loads the output with latency 1, result_o=0 and illegal_o=1.
  - illegal_o is 0 for every other op.

Test Plan:
- ADD 0x7FFFFFFF+1, then SRA 0x80000000>>4, back-to-back with out_ready_i=1 -> result_o 0x80000000 then 0xF8000000 on consecutive cycles; in_ready_o stays 1.
- DIV -7/2 -> in_ready_o=0 during cycles 1..34; out_valid_o at cycle 34 with 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- DIVU 100/0 -> 0xFFFFFFFF after 1 cycle. REM 0x80000000/0xFFFFFFFF -> 0 after 1 cycle.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- out_ready_i=0 for 5 cycles with out_valid_o=1 -> result_o and side_o stable, in_ready_o=0. Then raise out_ready_i -> next op accepted the same cycle.
- flush_i asserted in divide cycle 10 -> out_valid_o stays 0, in_ready_o=1 next cycle, and no stale result ever appears. Separately, rst_i pulsed mid-divide -> all outputs 0 asynchronously.
